// File: rtl/scan_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : scan_sequencer_if
//  Description : Control/status bundle between a scan controller and the
//                scan_sequencer that drives the 3-to-8 one-hot decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface scan_sequencer_if #(
    parameter int DWELL_W = 8
);
    logic               START;
    logic               STOP;
    logic               MODE;
    logic [DWELL_W-1:0] DWELL;
    logic [7:0]         MASK;
    logic [2:0]         A;
    logic               EN;
    logic               BUSY;
    logic               DONE;
    logic               WRAP;

    // Controller side: issues commands, observes decoder drive and status
    modport master (
        output START, STOP, MODE, DWELL, MASK,
        input  A, EN, BUSY, DONE, WRAP
    );

    // Sequencer side
    modport slave (
        input  START, STOP, MODE, DWELL, MASK,
        output A, EN, BUSY, DONE, WRAP
    );
endinterface
`default_nettype wire

// File: rtl/scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : scan_sequencer
//  Description : Steps a 3-to-8 one-hot decoder through the enabled channels
//                of a mask, holding each for DWELL+1 cycles. Continuous or
//                single-sweep operation with start/stop and DONE/WRAP pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_sequencer #(
    parameter int DWELL_W = 8,
    parameter int NUM_CH  = 8
) (
    input  wire logic        CLK,
    input  wire logic        RST_N,
    scan_sequencer_if.slave  bus
);
    // Channels at or above NUM_CH can never be selected
    localparam logic [7:0] c_ch_mask = 8'((9'd1 << NUM_CH) - 9'd1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t             r_state;
    logic [2:0]         r_a;
    logic               r_en;
    logic               r_busy;
    logic               r_done;
    logic               r_wrap;
    logic [DWELL_W-1:0] r_cnt;

    logic [7:0]         w_em;
    logic [2:0]         w_low;
    logic [2:0]         w_nxt;
    logic               w_wrap;

    // Lowest enabled channel; 0 when the mask is empty
    function automatic logic [2:0] lowest_set(input logic [7:0] em);
        logic [2:0] res;
        res = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (em[i]) res = 3'(i);
        end
        return res;
    endfunction

    // Next enabled channel strictly above cur, searching circularly; falls
    // back to cur itself when it is the only enabled channel
    function automatic logic [2:0] next_set(input logic [7:0] em, input logic [2:0] cur);
        logic [2:0] res;
        logic [2:0] idx;
        res = cur;
        for (int k = 7; k >= 1; k--) begin
            idx = cur + 3'(k);
            if (em[idx]) res = idx;
        end
        return res;
    endfunction

    // Effective mask and next-channel search for the advance point
    always_comb begin
        w_em   = bus.MASK & c_ch_mask;
        w_low  = lowest_set(w_em);
        w_nxt  = next_set(w_em, r_a);
        w_wrap = (w_nxt <= r_a);
    end

    // Scan state machine with registered decoder drive and status pulses
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_a     <= 3'd0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            r_wrap <= 1'b0;
            if (bus.STOP) begin
                // Abort immediately; the current dwell is not completed
                r_state <= ST_IDLE;
                r_en    <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_en   <= 1'b0;
                        r_busy <= 1'b0;
                        if (bus.START && (w_em != 8'd0)) begin
                            r_state <= ST_SCAN;
                            r_a     <= w_low;
                            r_en    <= 1'b1;
                            r_busy  <= 1'b1;
                            r_cnt   <= bus.DWELL;
                        end
                    end
                    ST_SCAN: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - DWELL_W'(1);
                        end else if ((w_em == 8'd0) || (w_wrap && bus.MODE)) begin
                            // Normal end: mask emptied, or single sweep completed
                            r_state <= ST_IDLE;
                            r_en    <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_a    <= w_nxt;
                            r_cnt  <= bus.DWELL;
                            r_wrap <= w_wrap;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.A    = r_a;
    assign bus.EN   = r_en;
    assign bus.BUSY = r_busy;
    assign bus.DONE = r_done;
    assign bus.WRAP = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_sequencer
//  Description : Scoreboard bench for scan_sequencer. Directed stimulus pushes
//                cycle-tagged expected outputs; a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_sequencer;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] dwell;
    logic [7:0] mask;
    int         cycle;
    int         total;
    int         bad;

    typedef struct {
        int         cyc;
        int         inst;
        logic [6:0] v;      // {A, EN, BUSY, DONE, WRAP}
        string      nm;
    } exp_t;

    exp_t exp_q[$];

    scan_sequencer_if #(.DWELL_W(8)) bus0 ();
    scan_sequencer_if #(.DWELL_W(8)) bus1 ();

    // Both instances see the same command inputs
    assign bus0.START = start;
    assign bus0.STOP  = stop;
    assign bus0.MODE  = mode;
    assign bus0.DWELL = dwell;
    assign bus0.MASK  = mask;
    assign bus1.START = start;
    assign bus1.STOP  = stop;
    assign bus1.MODE  = mode;
    assign bus1.DWELL = dwell;
    assign bus1.MASK  = mask;

    scan_sequencer #(.DWELL_W(8), .NUM_CH(8)) u_dut8 (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus0)
    );

    scan_sequencer #(.DWELL_W(8), .NUM_CH(5)) u_dut5 (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to tag expectations
    always @(posedge clk) cycle <= cycle + 1;

    // Wait for the edge that samples the current inputs, then record what
    // the selected instance must present after that edge
    task automatic tick(input int inst, input logic [2:0] a, input logic en,
                        input logic busy, input logic done, input logic wrap,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        e.cyc  = cycle;
        e.inst = inst;
        e.v    = {a, en, busy, done, wrap};
        e.nm   = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: compare on the falling edge, away from the active edge
    always @(negedge clk) begin
        logic [6:0] act;
        exp_t       e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cycle) begin
            e = exp_q.pop_front();
            act = (e.inst == 0) ? {bus0.A, bus0.EN, bus0.BUSY, bus0.DONE, bus0.WRAP}
                                : {bus1.A, bus1.EN, bus1.BUSY, bus1.DONE, bus1.WRAP};
            total = total + 1;
            if (e.cyc != cycle) begin
                bad = bad + 1;
                $display("FAIL %s: stale expectation cyc=%0d now=%0d", e.nm, e.cyc, cycle);
            end else if (act !== e.v) begin
                bad = bad + 1;
                $display("FAIL %s: cyc=%0d got {A,EN,BUSY,DONE,WRAP}=%b_%b want=%b_%b",
                         e.nm, cycle, act[6:4], act[3:0], e.v[6:4], e.v[3:0]);
            end
        end
    end

    initial begin
        cycle = 0;
        total = 0;
        bad   = 0;

        // Reset held with START and full mask: nothing may start
        rst_n = 1'b0;
        start = 1'b1;
        stop  = 1'b0;
        mode  = 1'b1;
        dwell = 8'd0;
        mask  = 8'hFF;
        tick(0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_c1");
        tick(0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_c2");

        // Release: START still high starts a single sweep at channel 0
        rst_n = 1'b1;
        tick(0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, "ss_start");
        start = 1'b0;
        for (int i = 1; i < 8; i++) tick(0, 3'(i), 1'b1, 1'b1, 1'b0, 1'b0, "ss_chan");
        tick(0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, "ss_done");
        tick(0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, "ss_idle");

        // Continuous scan over channels 2, 5, 7 with 3-cycle dwell
        mode  = 1'b0;
        mask  = 8'b1010_0100;
        dwell = 8'd2;
        start = 1'b1;
        tick(0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, "cont_first2");
        start = 1'b0;
        repeat (2) tick(0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, "cont_ch2");
        repeat (3) tick(0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, "cont_ch5");
        repeat (3) tick(0, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0, "cont_ch7");
        tick(0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, "cont_wrap");
        repeat (2) tick(0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, "cont_ch2b");
        tick(0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, "abort_ch5_c1");
        tick(0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, "abort_ch5_c2");

        // STOP with START in the second cycle of channel 5
        stop  = 1'b1;
        start = 1'b1;
        tick(0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, "abort_stop");
        stop  = 1'b0;
        start = 1'b0;
        tick(0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, "abort_idle");
        start = 1'b1;
        tick(0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, "restart");
        start = 1'b0;

        // Mask cleared mid-dwell: scan ends at the next advance point
        mask = 8'd0;
        tick(0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, "em_mid1");
        tick(0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, "em_mid2");
        tick(0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, "em_done");
        tick(0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, "em_after");

        // START with an empty mask is ignored
        start = 1'b1;
        repeat (2) tick(0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, "em_start_ignored");
        start = 1'b0;

        // NUM_CH=5 instance: single sweep over 0..4, two cycles each
        rst_n = 1'b0;
        tick(1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, "p5_reset");
        rst_n = 1'b1;
        mode  = 1'b1;
        mask  = 8'hFF;
        dwell = 8'd1;
        start = 1'b1;
        tick(1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, "p5_start");
        start = 1'b0;
        tick(1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, "p5_ch0");
        for (int c = 1; c < 5; c++) begin
            repeat (2) tick(1, 3'(c), 1'b1, 1'b1, 1'b0, 1'b0, "p5_chan");
        end
        tick(1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, "p5_done");
        tick(1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, "p5_idle");

        // Drain the scoreboard within a bounded number of cycles
        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scan_sequencer.md
# scan_sequencer

Upstream driver for the 3-to-8 one-hot decoder. Generates the 3-bit channel index `A` and enable `EN` that step the decoder through a programmable set of channels, holding each for a programmable dwell time. Supports continuous scanning and single-sweep operation, with start/stop control and sweep-status pulses for the surrounding control logic.

## Interface

Parameters:
- `DWELL_W`, default 8: width of the dwell-time input and internal counter.
- `NUM_CH`, default 8, legal range 1..8: channels `>= NUM_CH` are always treated as masked.

Ports:
- `CLK`, in, 1: single clock; all logic is on the rising edge.
- `RST_N`, in, 1: reset, synchronous, active-low.
- `START`, in, 1: level-sampled request to begin a scan; acted on only in IDLE.
- `STOP`, in, 1: abort. Has priority over every other event.
- `MODE`, in, 1: 0 = continuous scan, 1 = single sweep.
- `DWELL`, in, `DWELL_W`: each channel is held for `DWELL+1` cycles. Sampled at start and at every channel advance.
- `MASK`, in, 8: channel enable mask; bit i = 1 means channel i is visited. Sampled at start and at every advance.
- `A`, out, 3: registered channel index to the decoder.
- `EN`, out, 1: registered decoder enable.
- `BUSY`, out, 1: high while in SCAN.
- `DONE`, out, 1: one-cycle pulse when a scan ends normally.
- `WRAP`, out, 1: one-cycle pulse when continuous scan returns to the lowest enabled channel.

## Operation

- Effective mask: `EM = MASK & ((1<<NUM_CH)-1)`.
- States are IDLE and SCAN. Dwell counter `CNT` is `DWELL_W` bits wide.
- Reset (`RST_N` = 0 at a clock edge, any state): state = IDLE; `A`=0, `EN`=0, `BUSY`=0, `DONE`=0, `WRAP`=0, `CNT`=0. Reset aborts a scan in progress.
- IDLE:
  - `EN`=0, `BUSY`=0, and `A` holds its last value.
  - If `START`=1, `STOP`=0 and `EM`≠0: go to SCAN, set `A` = lowest set bit of `EM`, `EN`=1, `BUSY`=1, `CNT`=`DWELL`.
  - If `EM`=0, `START` is ignored.
- SCAN, when `CNT`≠0: decrement `CNT`. `START` is ignored.
- SCAN, when `CNT`=0 (advance point):
  - Compute `nxt` = next set bit of `EM` strictly above `A`, searching circularly.
  - A wrap occurs when `nxt <= A`. With a single enabled channel, every advance is a wrap.
  - If `EM`=0: `EN`=0, `BUSY`=0, `DONE`=1, go to IDLE, `A` holds.
  - Else if wrap and `MODE`=1: `EN`=0, `BUSY`=0, `DONE`=1, go to IDLE, `A` holds.
  - Else: `A`=`nxt`, `CNT`=`DWELL`, and `WRAP`=1 if this advance is a wrap.
- `STOP`=1 in any state: next state IDLE, `EN`=0, `BUSY`=0, `DONE`=0, `WRAP`=0, `A` holds. `START` and `STOP` both high in IDLE keeps the block in IDLE.
- `DONE` and `WRAP` are high for exactly one cycle and otherwise 0. They are never high together.
- `MODE` is sampled at each advance point. Changing it mid-scan takes effect at the next wrap.

## Timing

- All outputs are registered; there is no combinational input-to-output path.
- Start latency: `START` sampled at edge n → `EN`=1 and valid `A` from edge n, i.e. visible in cycle n+1.
- Each visited channel is presented for exactly `DWELL+1` cycles. `A` and `EN` change only on clock edges.
- `WRAP` rises on the same edge on which `A` returns to the lowest enabled channel.
- `DONE` rises on the same edge on which `EN` and `BUSY` fall.
- `STOP` sampled at edge n → `EN`=0 from edge n, with no partial-dwell completion.
- A new `START` is accepted in the first IDLE cycle after `DONE`. Back-to-back sweeps therefore have a minimum one-cycle `EN`=0 gap.
- Single sweep total: `EN` high for `popcount(EM)*(DWELL+1)` cycles.

## Test plan

- Reset: hold `RST_N`=0 for 2 cycles with `START`=1 and `MASK`=8'hFF → `A`=0, `EN`=`BUSY`=`DONE`=`WRAP`=0 throughout; after release, one cycle later `EN`=1 and `A`=0.
- Single sweep: `MODE`=1, `MASK`=8'hFF, `DWELL`=0, one-cycle `START` → `A`=0,1,…,7 one cycle each with `EN`=1 for 8 cycles, then `EN`=0, `BUSY`=0, `DONE`=1 for one cycle, and `A` stays 7.
- Continuous with skips: `MODE`=0, `MASK`=8'b1010_0100, `DWELL`=2 → `A`=2,5,7,2,5,7,… with each value lasting 3 cycles, and `WRAP`=1 for one cycle each time `A` returns to 2 (never on the first entry to 2).
- Abort: during the 2nd cycle of channel 5 in the previous setup, assert `STOP` and `START` together → `EN`=0 on the next edge, `A`=5, no `DONE`; a later `START` alone restarts at `A`=2.
- Empty mask: `START` with `MASK`=0 → stays IDLE with `EN`=0; separately, clear `MASK` to 0 mid-dwell in continuous mode → `DONE` pulse and `EN`=0 exactly at the next advance point.
- Parameter: `NUM_CH`=5 instance, `MODE`=1, `MASK`=8'hFF, `DWELL`=1 → `A`=0..4, two cycles each, then `DONE`; `A` never exceeds 4.
